// File: rtl/app_echo_pkg.sv
// Shared FSM type, depth limit and width helper for the echo application buffer.
package app_echo_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX      = 2'd1,
    ST_TX_LOAD = 2'd2,
    ST_TX      = 2'd3
  } echo_state_e;

  localparam int APP_ECHO_MAX_DEPTH = 256;

  // Bits needed to hold a byte count in the range 0..depth inclusive.
  function automatic int len_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/app_echo_bank_ram.sv
// Two-bank byte buffer: one write port, one synchronous read port, no reset,
// so it can be swapped for a foundry SRAM macro. Address MSB selects the bank.
module app_echo_bank_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [7:0]    wdata,
  input  logic [AW:0]   raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2*DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/app_echo_buffer.sv
// Echo application: captures each received INF into a ping-pong bank and replays it.
// Optional APP_ECHO_LEN_PREFIX_EN prefixes every reply with its payload length byte.
module app_echo_buffer
  import app_echo_pkg::*;
#(
  parameter int BUFF_DEPTH = 32,
  parameter int ADDR_W     = $clog2(BUFF_DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_soc,
  input  logic       rx_eoc,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_error,
  input  logic       app_resend_last,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  output logic       tx_last_byte,
  input  logic       tx_req,
  output logic       busy
);
  localparam int LEN_W = len_w(BUFF_DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(BUFF_DEPTH);
  localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);
`ifdef APP_ECHO_LEN_PREFIX_EN
  localparam logic PREFIX_EN = 1'b1;
`else
  localparam logic PREFIX_EN = 1'b0;
`endif

  echo_state_e       state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              ovf_q, ovf_d;
  logic [LEN_W-1:0]  reply_len_q, reply_len_d;
  logic              reply_valid_q, reply_valid_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              tx_valid_q, tx_valid_d;
  logic              prefix_q, prefix_d;

  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic [LEN_W-1:0]  rx_cnt;
  logic              rx_ovf;
  logic              at_last;

  app_echo_bank_ram #(.DEPTH(BUFF_DEPTH), .AW(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({wr_bank_q, wr_ptr_q[ADDR_W-1:0]}),
    .wdata (rx_data),
    .raddr ({~wr_bank_q, rd_ptr_q}),
    .rdata (ram_rdata)
  );

  // The reply bank is always the one not being written; it is read every cycle at rd_ptr.
  assign at_last = !prefix_q && ({1'b0, rd_ptr_q} == (reply_len_q - ONE_LEN));

  // Handshake: a byte is offered while tx_data_valid is high and is consumed by a
  // one-cycle tx_req; tx_req while tx_data_valid is low has no effect.
  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    wr_ptr_d      = wr_ptr_q;
    ovf_d         = ovf_q;
    reply_len_d   = reply_len_q;
    reply_valid_d = reply_valid_q;
    rd_ptr_d      = rd_ptr_q;
    tx_valid_d    = tx_valid_q;
    prefix_d      = prefix_q;
    ram_we        = 1'b0;
    rx_cnt        = wr_ptr_q;
    rx_ovf        = ovf_q;

    if (rx_soc) begin
      // Start of a new INF wins over everything, including an active reply.
      state_d    = ST_RX;
      wr_ptr_d   = '0;
      ovf_d      = 1'b0;
      tx_valid_d = 1'b0;
      prefix_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (app_resend_last && reply_valid_q) begin
            state_d  = ST_TX_LOAD;
            rd_ptr_d = '0;
          end
        end
        ST_RX: begin
          if (rx_data_valid) begin
            if (wr_ptr_q == DEPTH_LEN) begin
              rx_ovf = 1'b1;
            end else begin
              ram_we = 1'b1;
              rx_cnt = wr_ptr_q + ONE_LEN;
            end
          end
          wr_ptr_d = rx_cnt;
          ovf_d    = rx_ovf;
          if (rx_eoc) begin
            if (!rx_error && !rx_ovf && (rx_cnt != '0)) begin
              wr_bank_d     = ~wr_bank_q;
              reply_len_d   = rx_cnt;
              reply_valid_d = 1'b1;
              rd_ptr_d      = '0;
              state_d       = ST_TX_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_TX_LOAD: begin
          state_d    = ST_TX;
          tx_valid_d = 1'b1;
          prefix_d   = PREFIX_EN;
        end
        ST_TX: begin
          if (!tx_valid_q) begin
            tx_valid_d = 1'b1;
          end else if (tx_req) begin
            tx_valid_d = 1'b0;
            if (at_last) state_d = ST_IDLE;
            else if (prefix_q) prefix_d = 1'b0;
            else rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      ovf_q         <= 1'b0;
      reply_len_q   <= '0;
      reply_valid_q <= 1'b0;
      rd_ptr_q      <= '0;
      tx_valid_q    <= 1'b0;
      prefix_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      ovf_q         <= ovf_d;
      reply_len_q   <= reply_len_d;
      reply_valid_q <= reply_valid_d;
      rd_ptr_q      <= rd_ptr_d;
      tx_valid_q    <= tx_valid_d;
      prefix_q      <= prefix_d;
    end
  end

  // Outputs depend only on flops; the length prefix encodes 256 as 0x00 by truncation.
  assign tx_data       = !tx_valid_q ? 8'h00 : (prefix_q ? 8'(reply_len_q) : ram_rdata);
  assign tx_data_valid = tx_valid_q;
  assign tx_last_byte  = tx_valid_q && at_last;
  assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_app_echo_buffer.sv
// Bench for app_echo_buffer: directed cases plus random messages against a queue-based echo model.
module tb_app_echo_buffer;
  localparam int DEPTH = 8;
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_soc, rx_eoc, rx_data_valid, rx_error, app_resend_last, tx_req;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_data_valid, tx_last_byte, busy;

  int         tests_run = 0;
  int         tests_failed = 0;
  byte_q_t    last_reply;
  bit         reply_valid_m = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  app_echo_buffer #(.BUFF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_soc          (rx_soc),
    .rx_eoc          (rx_eoc),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .rx_error        (rx_error),
    .app_resend_last (app_resend_last),
    .tx_data         (tx_data),
    .tx_data_valid   (tx_data_valid),
    .tx_last_byte    (tx_last_byte),
    .tx_req          (tx_req),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one INF framed by rx_soc/rx_eoc; returns at the negedge just after the eoc edge.
  task automatic send_msg(input byte_q_t msg, input bit err, input bit eoc_with_last,
                          input bit resend_with_soc);
    int n;
    n = msg.size();
    rx_soc = 1'b1;
    app_resend_last = resend_with_soc;
    @(negedge clk);
    rx_soc = 1'b0;
    app_resend_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      rx_data = msg[i];
      rx_data_valid = 1'b1;
      if (!(eoc_with_last && i == n - 1)) begin
        @(negedge clk);
        rx_data_valid = 1'b0;
        rx_data = 8'($urandom_range(0, 255));
      end
    end
    rx_eoc = 1'b1;
    rx_error = err;
    @(negedge clk);
    rx_eoc = 1'b0;
    rx_error = 1'b0;
    rx_data_valid = 1'b0;
  endtask

  // Called one cycle after the triggering pulse; first byte must appear on the next cycle.
  task automatic expect_reply(input byte_q_t payload, input int abort_at);
    int n;
    exp_q.delete();
`ifdef APP_ECHO_LEN_PREFIX_EN
    exp_q.push_back(8'(payload.size()));
`endif
    foreach (payload[i]) exp_q.push_back(payload[i]);
    n = exp_q.size();
    check("latency_valid_low", tx_data_valid, 0);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("tx_valid", tx_data_valid, 1);
      check("tx_data", tx_data, exp_q[0]);
      check("tx_last", tx_last_byte, (i == n - 1));
      void'(exp_q.pop_front());
      if (i == abort_at) begin
        rx_soc = 1'b1;
        @(negedge clk);
        rx_soc = 1'b0;
        check("abort_valid", tx_data_valid, 0);
        check("abort_busy", busy, 1);
        return;
      end
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
      check("drop_valid", tx_data_valid, 0);
      if (i < n - 1) begin
        @(negedge clk);
      end else begin
        check("end_last_low", tx_last_byte, 0);
        check("end_busy", busy, 0);
      end
    end
  endtask

  task automatic expect_none();
    bit seen;
    seen = 1'b0;
    repeat (6) begin
      if (tx_data_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("no_reply_valid", seen, 0);
    check("no_reply_busy", busy, 0);
  endtask

  task automatic send_and_check(input byte_q_t msg, input bit err, input bit eoc_with_last,
                                input bit resend_with_soc, input int abort_at);
    send_msg(msg, err, eoc_with_last, resend_with_soc);
    if (!err && msg.size() > 0 && msg.size() <= DEPTH) begin
      last_reply = msg;
      reply_valid_m = 1'b1;
      expect_reply(msg, abort_at);
    end else begin
      expect_none();
    end
  endtask

  task automatic resend_and_check();
    app_resend_last = 1'b1;
    @(negedge clk);
    app_resend_last = 1'b0;
    if (reply_valid_m) expect_reply(last_reply, -1);
    else expect_none();
  endtask

  initial begin
    byte_q_t m;
    rst_n = 1'b0;
    rx_soc = 1'b0; rx_eoc = 1'b0; rx_data = 8'h00; rx_data_valid = 1'b0;
    rx_error = 1'b0; app_resend_last = 1'b0; tx_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_data_valid, 0);
    check("rst_tx_last", tx_last_byte, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    resend_and_check();

    m = '{8'h01, 8'h02, 8'h03};
    send_and_check(m, 1'b0, 1'b0, 1'b0, -1);
    m = '{8'hAA, 8'h55};
    send_and_check(m, 1'b0, 1'b1, 1'b0, -1);
    resend_and_check();
    m = '{8'h10};
    send_and_check(m, 1'b1, 1'b0, 1'b0, -1);
    resend_and_check();
    m.delete();
    send_and_check(m, 1'b0, 1'b0, 1'b0, -1);

    m.delete();
    for (int i = 0; i < DEPTH + 1; i++) m.push_back(8'(8'h40 + i));
    send_and_check(m, 1'b0, 1'b0, 1'b0, -1);
    resend_and_check();
    m.delete();
    for (int i = 0; i < DEPTH; i++) m.push_back(8'(8'hC0 + i));
    send_and_check(m, 1'b0, 1'b1, 1'b0, -1);

    m = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    send_and_check(m, 1'b0, 1'b0, 1'b0, 2);
    m = '{8'h99};
    send_and_check(m, 1'b1, 1'b1, 1'b0, -1);
    resend_and_check();
    m = '{8'h77};
    send_and_check(m, 1'b0, 1'b0, 1'b1, -1);
    resend_and_check();

    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(0, DEPTH + 1);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
      send_and_check(m, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 2) == 0) resend_and_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/app_echo_buffer.md
Name: app_echo_buffer

Overview:
- Application-side block that connects to the ISO 14443A core's application Rx/Tx byte interfaces.
- Captures the INF field of each received STD I-Block into a ping-pong buffer, then returns it as the reply (echo).
- Keeps the last reply intact so it can be replayed when the core asserts app_resend_last.
- Reference application for bring-up and for end-to-end verification of the part-4 layer.

Parameters:
- BUFF_DEPTH, 32, bytes per bank; power of 2, range 4 to 256.
- ADDR_W, $clog2(BUFF_DEPTH), derived; not to be overridden.

Ports:
- clk  in  1  13.56MHz recovered carrier clock
- rst_n  in  1  asynchronous active-low reset
- rx_soc  in  1  one-cycle pulse: start of received INF
- rx_eoc  in  1  one-cycle pulse: end of received INF
- rx_data  in  8  received byte, valid when rx_data_valid
- rx_data_valid  in  1  one-cycle strobe per received byte
- rx_error  in  1  message corrupt; qualified at rx_eoc
- app_resend_last  in  1  one-cycle pulse: replay previous reply
- tx_data  out  8  reply byte
- tx_data_valid  out  1  reply byte available
- tx_last_byte  out  1  tx_data is the final byte of the reply
- tx_req  in  1  one-cycle pulse: current byte consumed
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_bank=0; reply_len=0; reply_valid=0.
- Storage is two banks of BUFF_DEPTH bytes.
  - wr_bank is the bank being written; the other bank holds the last reply.
  - Storage is not reset; only pointers, lengths and flags are.
- FSM states: IDLE, RX, TX_LOAD, TX.

IDLE:
- rx_soc → RX; wr_ptr=0; ovf=0.
- app_resend_last with reply_valid=1 → TX_LOAD from the reply bank with reply_len.
- app_resend_last with reply_valid=0 → ignored.
- If rx_soc and app_resend_last arrive in the same cycle, rx_soc wins.

RX:
- Each rx_data_valid writes rx_data to wr_bank[wr_ptr] and increments wr_ptr.
- Once wr_ptr == BUFF_DEPTH, further bytes are dropped and ovf is set.
- rx_eoc: commit only if rx_error=0, ovf=0 and wr_ptr>0; otherwise → IDLE with no reply and the banks untouched.
- Commit actions:
  - toggle wr_bank;
  - reply_len=wr_ptr, where 0 < reply_len ≤ BUFF_DEPTH (reply_len is ADDR_W+1 bits);
  - reply_valid=1;
  - → TX_LOAD.
- rx_data_valid and rx_eoc in the same cycle: write the byte first, then evaluate the eoc using the updated count.
- A repeated rx_soc restarts RX (wr_ptr=0, ovf=0).

TX_LOAD:
- Lasts one cycle for the synchronous memory read of rd_ptr=0.
- → TX with tx_data_valid=1.
- First tx_data_valid occurs 2 cycles after the rx_eoc or app_resend_last pulse.

TX:
- tx_data=bank[rd_ptr]; tx_last_byte=(rd_ptr==reply_len-1).
- tx_req on a non-last byte: rd_ptr++, and tx_data_valid drops for exactly one cycle (read latency) before the next byte is presented.
- tx_req on the last byte: tx_data_valid=0 and tx_last_byte=0 in the next cycle; → IDLE.
- rx_soc during TX or TX_LOAD: abort (tx_data_valid=0 next cycle) → RX.
  - The reply bank is preserved, so a later resend returns the full reply.
- app_resend_last outside IDLE is ignored.
- Outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro: APP_ECHO_LEN_PREFIX_EN.
- When defined:
  - the reply is prefixed with one byte equal to reply_len[7:0] (the value 256 encodes as 0x00);
  - the reply is reply_len+1 bytes;
  - tx_last_byte is asserted on the final payload byte;
  - resend also includes the prefix.
- When undefined, the reply is the payload only.

Decomposition:
- Shared package app_echo_pkg holds:
  - typedef enum for the FSM states;
  - localparam APP_ECHO_MAX_DEPTH=256;
  - function len_w(depth).
- Sub-module app_echo_bank_ram: 2×BUFF_DEPTH×8, one write port and one synchronous read port, no reset; keeps the buffer replaceable by a foundry SRAM macro.

Test Plan:
- Rx {0x01,0x02,0x03}, no error → after 2 cycles the Tx stream is 01,02,03, tx_last_byte only on 03, then busy=0.
- Echo {0xAA,0x55}, then app_resend_last in IDLE → AA,55 replayed exactly; also the reset-then-resend case → no tx_data_valid.
- Rx {0x10} with rx_error=1 at rx_eoc; resend → previous reply replayed, not 0x10. Zero-byte message → no reply.
- BUFF_DEPTH=4, Rx of 5 bytes → no reply (overflow). Exactly 4 bytes → 4-byte echo.
- During Tx of a 6-byte reply, rx_soc after byte 2 → tx_data_valid low next cycle. New 1-byte message 0x77 → echo 77. Resend → 77.
- With APP_ECHO_LEN_PREFIX_EN, Rx {0xDE,0xAD} → 02,DE,AD with tx_last_byte on AD.
